memory_controller: RTL and testbench

Single-port-write / single-port-read word memory controller with an internal synchronous RAM. It accepts one 32-bit word write and one 32-bit word read per cycle on byte addresses, range- and alignment-checked. It returns registered read data with a validity flag. It sits between a simple master (CPU/test wrapper) and on-chip storage.

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_ctrl_ram.sv | 44 ++++
 rtl/memory_controller.sv | 80 ++++++++
 tb/tb_memory_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared defaults and helpers for the word memory controller.
//   MEM_DATA_W : default data word width
//   MEM_ADDR_W : default byte-address width
//   MEM_DEPTH  : default number of words (power of two)
//   MEM_IDX_W  : word-index width derived from MEM_DEPTH
//   addr_legal : alignment + range check used by both the write and read port
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DEPTH  = 256;
    localparam int unsigned MEM_IDX_W  = $clog2(MEM_DEPTH);

    // The address is passed zero-extended to 64 bits so one function serves
    // any ADDR_W up to 64 without per-instance copies.
    function automatic logic addr_legal(input logic [63:0] addr,
                                        input int unsigned depth);
        return (addr[1:0] == 2'b00) && (addr[63:2] < 62'(depth));
    endfunction

endpackage

// File: rtl/mem_ctrl_ram.sv
// ---------------------------------------------------------------------------
// mem_ctrl_ram
// DEPTH x DATA_W storage array with one write port and one read port.
// Ports:
//   clk      : write clock, rising edge
//   we_i     : write strobe (already gated for legality and reset)
//   waddr_i  : write word index
//   wdata_i  : write word
//   raddr_i  : read word index
//   rdata_o  : read word, captured by the output register in the top
// The array has no reset, so its contents survive a controller reset.
// ---------------------------------------------------------------------------
module mem_ctrl_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[raddr_i == raddr_i ? waddr_i : waddr_i] <= wdata_i;
        end
    end

    // Write-first: a read of the word being written on this edge sees the
    // new data instead of the stale array contents.
    always_comb begin
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/memory_controller.sv
// ---------------------------------------------------------------------------
// memory_controller
// Word memory with one write and one read per cycle on byte addresses.
// Ports:
//   clk           : sole clock, rising edge
//   reset         : asynchronous active-high reset (clears outputs only)
//   write_enable  : write request, sampled every rising edge
//   write_address : byte address of the write
//   write_data    : word to write
//   read_address  : byte address read every cycle
//   read_data     : registered read word (0 when the address is illegal)
//   read_enable   : high when read_data holds a legal word read
// ---------------------------------------------------------------------------
module memory_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    output logic              read_enable,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] read_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              wr_legal;
    logic              rd_legal;
    logic              wr_en;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] read_data_d;
    logic [DATA_W-1:0] read_data_q;
    logic              read_enable_d;
    logic              read_enable_q;

    assign wr_legal = addr_legal(64'(write_address), DEPTH);
    assign rd_legal = addr_legal(64'(read_address), DEPTH);

    // Writes are dropped while reset is high so a reset overlapping a write
    // edge cannot corrupt the retained contents.
    assign wr_en = write_enable && wr_legal && !reset;

    mem_ctrl_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (write_address[IDX_W+1:2]),
        .wdata_i (write_data),
        .raddr_i (read_address[IDX_W+1:2]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        read_data_d   = rd_legal ? ram_rdata : '0;
        read_enable_d = rd_legal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q   <= '0;
            read_enable_q <= 1'b0;
        end else begin
            read_data_q   <= read_data_d;
            read_enable_q <= read_enable_d;
        end
    end

    assign read_data   = read_data_q;
    assign read_enable = read_enable_q;

endmodule

// File: tb/tb_memory_controller.sv
// ---------------------------------------------------------------------------
// tb_memory_controller
// Directed bench for memory_controller. A reference memory model predicts
// each read; predictions are queued when inputs are driven and popped when
// the registered output appears one edge later.
// ---------------------------------------------------------------------------
module tb_memory_controller;

    typedef struct {
        logic [31:0] data;
        logic        en;
        string       tag;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic        read_enable;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;

    expect_t     scoreboard [$];
    logic [31:0] model [int];
    int          compared = 0;
    int          mismatched = 0;

    memory_controller dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    // Legal: word aligned and inside the 256-word (1 KiB) window.
    function automatic logic isLegal(input logic [31:0] addr);
        return (addr % 4 == 0) && (addr <= 32'h3FC);
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pops the oldest prediction and compares it with the current outputs.
    task automatic checkOutput();
        expect_t e;
        if (scoreboard.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = scoreboard.pop_front();
            checkValue({e.tag, "_data"}, read_data, e.data);
            checkValue({e.tag, "_en"}, {31'b0, read_enable}, {31'b0, e.en});
        end
    endtask

    // Drives one cycle of inputs from a negedge, predicts the result of the
    // coming edge, then checks it on the following negedge.
    task automatic applyStimulus(input string tag, input logic we,
                                 input logic [31:0] wa, input logic [31:0] wd,
                                 input logic [31:0] ra);
        expect_t e;
        write_enable  = we;
        write_address = wa;
        write_data    = wd;
        read_address  = ra;
        e.tag = tag;
        if (isLegal(ra)) begin
            e.en = 1'b1;
            if (we && isLegal(wa) && (wa == ra)) e.data = wd;
            else e.data = model[int'(ra / 4)];
        end else begin
            e.en   = 1'b0;
            e.data = 32'h0;
        end
        if (we && isLegal(wa)) model[int'(wa / 4)] = wd;
        scoreboard.push_back(e);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic [31:0] rnd [16];

        // Reset with garbage inputs, including a write that must be ignored.
        write_enable  = 1'b1;
        write_address = 32'h0000_0010;
        write_data    = 32'h5555_AAAA;
        read_address  = 32'h0000_0010;
        #1;
        checkValue("reset_now_data", read_data, 32'h0);
        checkValue("reset_now_en", {31'b0, read_enable}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkValue("reset_held_data", read_data, 32'h0);
        checkValue("reset_held_en", {31'b0, read_enable}, 32'h0);
        reset = 1'b0;

        // Basic write/read and illegal reads.
        applyStimulus("wr10_rd_misaligned", 1'b1, 32'h10, 32'hDEADBEEF, 32'h11);
        applyStimulus("rd10", 1'b0, 32'h0, 32'h0, 32'h10);
        applyStimulus("wr3fc_rd_range", 1'b1, 32'h3FC, 32'h12345678, 32'h400);
        applyStimulus("rd3fc", 1'b0, 32'h0, 32'h0, 32'h3FC);

        // Illegal writes must not disturb word 0x10 (0x12 aliases its index).
        applyStimulus("wr400_ignored", 1'b1, 32'h400, 32'hFFFFFFFF, 32'h10);
        applyStimulus("wr12_ignored", 1'b1, 32'h12, 32'hFFFFFFFF, 32'h10);
        applyStimulus("rd10_again", 1'b0, 32'h0, 32'h0, 32'h10);

        // Same-edge collision returns the new data.
        applyStimulus("collide20", 1'b1, 32'h20, 32'hCAFEF00D, 32'h20);

        // Back-to-back writes then reads.
        applyStimulus("b2b_wr0", 1'b1, 32'h0, 32'h1, 32'h20);
        applyStimulus("b2b_wr4", 1'b1, 32'h4, 32'h2, 32'h3FC);
        applyStimulus("b2b_wr8", 1'b1, 32'h8, 32'h3, 32'h10);
        applyStimulus("b2b_rd0", 1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus("b2b_rd4", 1'b0, 32'h0, 32'h0, 32'h4);
        applyStimulus("b2b_rd8", 1'b0, 32'h0, 32'h0, 32'h8);

        // Reset mid-operation: outputs clear at once, contents are retained,
        // and the write on the reset edge is dropped.
        applyStimulus("wr40", 1'b1, 32'h40, 32'hA5A5A5A5, 32'h10);
        write_enable  = 1'b1;
        write_address = 32'h40;
        write_data    = 32'h0BADF00D;
        read_address  = 32'h10;
        #2;
        reset = 1'b1;
        #1;
        checkValue("midreset_now_data", read_data, 32'h0);
        checkValue("midreset_now_en", {31'b0, read_enable}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkValue("midreset_held_data", read_data, 32'h0);
        checkValue("midreset_held_en", {31'b0, read_enable}, 32'h0);
        reset = 1'b0;
        write_enable = 1'b0;
        applyStimulus("rd40_after_reset", 1'b0, 32'h0, 32'h0, 32'h40);

        // Random words into 0x100..0x13C, then read them back in random order.
        for (int i = 0; i < 16; i++) begin
            rnd[i] = $urandom;
            applyStimulus("rnd_wr", 1'b1, 32'h100 + 32'(i * 4), rnd[i], 32'h3FC);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus("rnd_rd", 1'b0, 32'h0, 32'h0,
                          32'h100 + 32'($urandom_range(0, 15) * 4));
        end

        if (scoreboard.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", scoreboard.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
